// File: rtl/uart_word_arbiter_pkg.sv
// Shared types and constants for the UART word arbiter and its round-robin picker.
// Holds the arbiter state encoding and the rors direction encoding.
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;

  localparam logic SEND = 1'b1;
  localparam logic RECV = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    NEXT    = 3'd4,
    ACK     = 3'd5
  } arb_state_t;

  // Index of the final byte of a transfer: 0 for single bytes, BPW-1 for words.
  function automatic logic [1:0] last_byte_idx(input logic word, input int bpw);
    logic [1:0] last_idx;
    if (word) begin
      last_idx = 2'(bpw - 1);
    end else begin
      last_idx = 2'd0;
    end
    return last_idx;
  endfunction

endpackage

// File: rtl/uart_word_arbiter_if.sv
// Byte-level handshake between the word arbiter (master) and the shared uart_unit (slave).
interface uart_word_arbiter_if;

  logic       uart_go;
  logic       rors;
  logic [7:0] txdata;
  logic [7:0] rxdata;
  logic       uart_done;

  modport master (
    output uart_go,
    output rors,
    output txdata,
    input  rxdata,
    input  uart_done
  );

  modport slave (
    input  uart_go,
    input  rors,
    input  txdata,
    output rxdata,
    output uart_done
  );

endinterface

// File: rtl/uart_word_arbiter_rr_grant.sv
// Two-way round-robin picker; the last-granted port loses a tie and the
// history only moves when a grant is actually issued.
module uart_rr_grant (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic grant_o,
  output logic owner_o
);

  logic last_q;
  logic last_d;

  // Pick a winner while sampling is enabled and update the history on grant.
  always_comb begin
    grant_o = 1'b0;
    owner_o = 1'b0;
    last_d  = last_q;
    if (en_i && (req0_i || req1_i)) begin
      grant_o = 1'b1;
      if (req0_i && req1_i) begin
        owner_o = ~last_q;
      end else begin
        owner_o = req1_i;
      end
      last_d = owner_o;
    end else begin
      last_d = last_q;
    end
  end

  // Last-granted register; resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_word_arbiter.sv
// Shares one uart_unit between a loader port (0) and a core I/O port (1), splitting
// word transfers into single-byte UART transactions assembled little-endian.
module uart_word_arbiter #(
  parameter int BYTES_PER_WORD = uart_pkg::BYTES_PER_WORD
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       wr0,
  input  logic                       wr1,
  input  logic                       word0,
  input  logic                       word1,
  input  logic [31:0]                wdata0,
  input  logic [31:0]                wdata1,
  output logic [31:0]                rdata0,
  output logic [31:0]                rdata1,
  output logic                       ack0,
  output logic                       ack1,
  output logic                       busy,
  uart_word_arbiter_if.master        bus
);

  import uart_pkg::*;

  arb_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic        word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        grant_s;
  logic        owner_s;
  logic        go_s;
  logic        rors_s;
  logic [7:0]  txdata_s;

  uart_rr_grant u_grant (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (state_q == IDLE),
    .req0_i  (req0),
    .req1_i  (req1),
    .grant_o (grant_s),
    .owner_o (owner_s)
  );

  // Next-state logic: byte sequencing, receive assembly and result delivery.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          owner_d = owner_s;
          wr_d    = owner_s ? wr1    : wr0;
          word_d  = owner_s ? word1  : word0;
          wdata_d = owner_s ? wdata1 : wdata0;
          buf_d   = 32'h0000_0000;
          idx_d   = 2'd0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.uart_done) begin
          state_d = wr_q ? NEXT : CAPTURE;
        end else begin
          state_d = WAIT;
        end
      end
      CAPTURE: begin
        // rxdata is registered by uart_unit on its done cycle, so it is stable here.
        buf_d[{idx_q, 3'b000} +: 8] = bus.rxdata;
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == last_byte_idx(word_q, BYTES_PER_WORD)) begin
          state_d = ACK;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ISSUE;
        end
      end
      ACK: begin
        if (!wr_q) begin
          if (owner_q) begin
            rdata1_d = buf_q;
          end else begin
            rdata0_d = buf_q;
          end
        end else begin
          rdata0_d = rdata0_q;
          rdata1_d = rdata1_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; a reset mid-transfer drops the partial word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      word_q   <= 1'b0;
      wdata_q  <= 32'h0000_0000;
      buf_q    <= 32'h0000_0000;
      rdata0_q <= 32'h0000_0000;
      rdata1_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Moore output decode from the state register and latched request fields.
  always_comb begin
    go_s     = 1'b0;
    rors_s   = RECV;
    txdata_s = 8'h00;
    if (state_q == ISSUE) begin
      go_s     = 1'b1;
      rors_s   = wr_q ? SEND : RECV;
      txdata_s = wdata_q[{idx_q, 3'b000} +: 8];
    end else begin
      go_s     = 1'b0;
      rors_s   = RECV;
      txdata_s = 8'h00;
    end
  end

  // Requester-side status decode.
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    busy = (state_q != IDLE);
    if (state_q == ACK) begin
      ack0 = ~owner_q;
      ack1 = owner_q;
    end else begin
      ack0 = 1'b0;
      ack1 = 1'b0;
    end
  end

  assign bus.uart_go = go_s;
  assign bus.rors    = rors_s;
  assign bus.txdata  = txdata_s;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Directed bench for uart_word_arbiter with a negedge uart_unit stub and transaction logger.
module tb_uart_word_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        wr0 = 1'b0, wr1 = 1'b0;
  logic        word0 = 1'b0, word1 = 1'b0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, busy;

  uart_word_arbiter_if bus();

  uart_word_arbiter dut (
    .clk    (clk),
    .rstn   (rstn),
    .req0   (req0),
    .req1   (req1),
    .wr0    (wr0),
    .wr1    (wr1),
    .word0  (word0),
    .word1  (word1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .ack0   (ack0),
    .ack1   (ack1),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Stub/monitor state, written only by the negedge process below.
  int         cyc = 0;
  int         go_cnt = 0;
  int         last_go_cyc = 0;
  int         min_gap = 1000;
  int         stub_cnt = 0;
  int         done_cyc = 0;
  int         rx_cnt = 0;
  int         ack0_cnt = 0, ack1_cnt = 0;
  int         ack0_cyc = 0, ack1_cyc = 0;
  int         ack_n = 0;
  logic [7:0] tx_log [256];
  logic       rors_log [256];
  logic       ack_log [64];
  // Written only by the main process.
  int         stub_wait = 1;
  logic [7:0] rx_mem [256];

  // uart_unit stub: done after stub_wait WAIT cycles, rxdata valid only from the next cycle.
  initial begin
    bus.uart_done = 1'b0;
    bus.rxdata    = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        stub_cnt      = 0;
        bus.uart_done = 1'b0;
      end else if (bus.uart_done) begin
        bus.uart_done = 1'b0;
        bus.rxdata    = rx_mem[rx_cnt % 256];
        rx_cnt++;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus.uart_done = 1'b1;
          bus.rxdata    = 8'hEE;
          done_cyc      = cyc;
        end
      end
      if (rstn && bus.uart_go) begin
        if (go_cnt > 0 && (cyc - last_go_cyc) < min_gap) min_gap = cyc - last_go_cyc;
        tx_log[go_cnt % 256]   = bus.txdata;
        rors_log[go_cnt % 256] = bus.rors;
        go_cnt++;
        last_go_cyc = cyc;
        stub_cnt    = stub_wait;
      end
      if (ack0) begin
        ack0_cnt++;
        ack0_cyc = cyc;
        ack_log[ack_n % 64] = 1'b0;
        ack_n++;
      end
      if (ack1) begin
        ack1_cnt++;
        ack1_cyc = cyc;
        ack_log[ack_n % 64] = 1'b1;
        ack_n++;
      end
    end
  end

  // Single-port request: hold req until ack, drop it, then step into the following IDLE cycle.
  task automatic xfer(input logic port);
    logic seen = 1'b0;
    if (port) req1 = 1'b1; else req0 = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #2;
      if ((port ? ack1 : ack0) === 1'b1) seen = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("xfer_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #2;
    chk("xfer_busy_after", 32'(busy), 32'd0);
  endtask

  // Both ports request in the same cycle; each drops its req in its own ack cycle.
  task automatic pair_run();
    logic s0 = 1'b0, s1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 600 && !(s0 && s1); i++) begin
      @(posedge clk); #2;
      if (!s0 && ack0 === 1'b1) begin s0 = 1'b1; req0 = 1'b0; end
      if (!s1 && ack1 === 1'b1) begin s1 = 1'b1; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("pair_both_acked", 32'({s0, s1}), 32'd3);
    @(posedge clk); #2;
  endtask

  initial begin
    int         base, na0, na1, an;
    logic       any_rors;
    logic [7:0] exp_tx [8];
    logic       seen;

    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;

    // Reset state
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_go",     32'(bus.uart_go), 32'd0);
    chk("rst_rors",   32'(bus.rors), 32'd0);
    chk("rst_txdata", 32'(bus.txdata), 32'd0);
    chk("rst_acks",   32'({ack0, ack1}), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);

    // 1-byte write on port 1; counting the done cycle as the first, ack lands in the third
    stub_wait = 1;
    base = go_cnt; na0 = ack0_cnt;
    wr1 = 1'b1; word1 = 1'b0; wdata1 = 32'h0000_00A5;
    xfer(1'b1);
    chk("t1_go_count", 32'(go_cnt - base), 32'd1);
    chk("t1_txdata",   32'(tx_log[base]), 32'h0000_00A5);
    chk("t1_rors",     32'(rors_log[base]), 32'd1);
    chk("t1_ack_lat",  32'(ack1_cyc - done_cyc), 32'd2);
    chk("t1_rdata1",   rdata1, 32'd0);
    chk("t1_p0_quiet", 32'(ack0_cnt - na0), 32'd0);

    // 4-byte read on port 0
    stub_wait = 2;
    base = go_cnt; na1 = ack1_cnt;
    rx_mem[(rx_cnt + 0) % 256] = 8'h78;
    rx_mem[(rx_cnt + 1) % 256] = 8'h56;
    rx_mem[(rx_cnt + 2) % 256] = 8'h34;
    rx_mem[(rx_cnt + 3) % 256] = 8'h12;
    wr0 = 1'b0; word0 = 1'b1; wdata0 = 32'hDEAD_BEEF;
    xfer(1'b0);
    any_rors = 1'b0;
    for (int k = 0; k < 4; k++) any_rors = any_rors | rors_log[(base + k) % 256];
    chk("t2_go_count", 32'(go_cnt - base), 32'd4);
    chk("t2_rors",     32'(any_rors), 32'd0);
    chk("t2_rdata0",   rdata0, 32'h1234_5678);
    chk("t2_ack_lat",  32'(ack0_cyc - done_cyc), 32'd3);
    chk("t2_rdata1",   rdata1, 32'd0);
    chk("t2_p1_quiet", 32'(ack1_cnt - na1), 32'd0);

    // 1-byte read on port 1 must zero-extend
    stub_wait = 1;
    rx_mem[rx_cnt % 256] = 8'hFF;
    wr1 = 1'b0; word1 = 1'b0; wdata1 = 32'h0;
    xfer(1'b1);
    chk("t3_rdata1", rdata1, 32'h0000_00FF);
    chk("t3_rdata0", rdata0, 32'h1234_5678);

    // Simultaneous 4-byte writes, port 1 granted last -> port 0 first
    base = go_cnt; an = ack_n;
    wr0 = 1'b1; word0 = 1'b1; wdata0 = 32'h1122_3344;
    wr1 = 1'b1; word1 = 1'b1; wdata1 = 32'hAABB_CCDD;
    pair_run();
    exp_tx = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk("t4_go_count", 32'(go_cnt - base), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("t4_tx%0d", k), 32'(tx_log[(base + k) % 256]), 32'(exp_tx[k]));
    chk("t4_order", 32'({ack_log[an % 64], ack_log[(an + 1) % 64]}), 32'b01);

    // Port 0 goes alone first, so it is last-granted; its write leaves rdata0 alone
    wr0 = 1'b1; word0 = 1'b0; wdata0 = 32'h0000_0033;
    xfer(1'b0);
    chk("t5_rdata0_kept", rdata0, 32'h1234_5678);
    base = go_cnt; an = ack_n;
    wdata0 = 32'h1122_3344; word0 = 1'b1;
    pair_run();
    exp_tx = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 8; k++) chk($sformatf("t5_tx%0d", k), 32'(tx_log[(base + k) % 256]), 32'(exp_tx[k]));
    chk("t5_order", 32'({ack_log[an % 64], ack_log[(an + 1) % 64]}), 32'b10);

    // Reset during the third byte of a 4-byte read
    stub_wait = 2;
    base = go_cnt; na0 = ack0_cnt;
    for (int k = 0; k < 4; k++) rx_mem[(rx_cnt + k) % 256] = 8'h90 + 8'(k);
    wr0 = 1'b0; word0 = 1'b1;
    req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #2;
      if (go_cnt - base >= 3) seen = 1'b1;
    end
    chk("t6_third_byte", 32'(seen), 32'd1);
    chk("t6_rdata0_pre", rdata0, 32'h1234_5678);
    rstn = 1'b0;
    req0 = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    chk("t6_busy",   32'(busy), 32'd0);
    chk("t6_go",     32'(bus.uart_go), 32'd0);
    chk("t6_rdata0", rdata0, 32'd0);
    chk("t6_ack0",   32'(ack0), 32'd0);
    repeat (10) @(posedge clk);
    #2;
    chk("t6_no_ack",   32'(ack0_cnt - na0), 32'd0);
    chk("t6_idle",     32'(busy), 32'd0);
    stub_wait = 1;
    rx_mem[rx_cnt % 256] = 8'h5A;
    word0 = 1'b0;
    xfer(1'b0);
    chk("t6_fresh_rdata0", rdata0, 32'h0000_005A);

    chk("go_spacing", 32'(min_gap >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
